mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning max cycles in BUSY waiting for memOpDone before abort (legal range 2..255).
REQ-002 SHALL have parameter AW, default 32, meaning address width; data width fixed at 32.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req0, req1  input  1 each  transaction request from requester 0 / 1, held until ack.
REQ-007 we0, we1  input  1 each  1: write, 0: read; stable while req high.
REQ-008 addr0, addr1  input  AW each  transaction address; stable while req high.
REQ-009 wdata0, wdata1  input  32 each  write data; stable while req high.
REQ-010 ack0, ack1  output  1 each  one-cycle completion pulse to requester.
REQ-011 err  output  1  high in the ack cycle when the transaction timed out.
REQ-012 rdata  output  32  read data, valid in the ack cycle.
REQ-013 addressBus  output  AW  memory address.
REQ-014 memWData  output  32  memory write data (top level tristates onto dataBus).
REQ-015 memRWPin  output  1  1: write, 0: read.
REQ-016 memValid  output  1  high while a memory transaction is presented.
REQ-017 memRData  input  32  memory read data.
REQ-018 memOpDone  input  1  memory completion level, may stay high several cycles.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY, RELEASE.
REQ-020 IDLE: on an edge with any req high, SHALL grant one requester, register its addr/we/wdata onto addressBus/memRWPin/memWData, set memValid=1, clear timeout counter, enter BUSY.
REQ-021 Arbitration SHALL be round-robin: both req high -> grant the requester not served last; single req -> grant it.
REQ-022 Last-served pointer SHALL update only on grant.
REQ-023 BUSY: memValid, addressBus, memRWPin, memWData SHALL stay constant.
REQ-024 BUSY with memOpDone=1: SHALL capture memRData into rdata (reads only; writes leave rdata unchanged), pulse ack of granted requester one cycle, drop memValid, enter RELEASE.
REQ-025 BUSY with memOpDone=0: counter increments; when counter reaches TIMEOUT-1, SHALL pulse ack and err together, drop memValid, enter RELEASE; rdata unchanged.
REQ-026 memOpDone and timeout on the same edge: memOpDone SHALL win, err=0.
REQ-027 RELEASE: SHALL wait until memOpDone=0 (sampled), then enter IDLE; no new grant in RELEASE.
REQ-028 Latency: req sampled in IDLE at edge N -> memValid high after edge N; memOpDone sampled at edge M -> ack high after edge M, for exactly one cycle.
REQ-029 Requester SHALL deassert req the cycle after ack; arbiter does not sample req until IDLE (at least 2 edges after ack).
REQ-030 memRWPin SHALL be 0 whenever memValid=0.
REQ-031 At most one ack SHALL be high in any cycle; only one transaction outstanding.

Reset
REQ-032 On reset assertion, asynchronously: state=IDLE, memValid=0, memRWPin=0, addressBus=0, memWData=0, rdata=0, ack0=ack1=0, err=0, counter=0, last-served=1 (requester 0 wins first tie).
REQ-033 Reset mid-transaction SHALL abort with no ack; memory side sees memValid drop immediately.

Verification
REQ-034 req0 read addr 0x10, memory asserts memOpDone 3 cycles later with memRData=0xDEADBEEF -> ack0 one cycle, rdata=0xDEADBEEF, err=0, memRWPin=0 throughout.
REQ-035 req1 write addr 0x20 data 0x55 -> addressBus=0x20, memWData=0x55, memRWPin=1 until memOpDone, then ack1, memRWPin=0.
REQ-036 req0 and req1 both held high out of reset -> grants order 0,1,0,1 across four transactions.
REQ-037 memOpDone never asserted, TIMEOUT=8 -> ack and err high together 8 cycles after memValid rises, memValid=0 after.
REQ-038 memOpDone held high 4 cycles -> single ack; next grant only after memOpDone low.
REQ-039 Reset asserted during BUSY -> all outputs reset values immediately, no ack; next request after reset served normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// ---------------
// Purpose: shares one memory bus between two requesters. A request is
// granted round-robin, presented on the memory side until the memory reports
// completion (or a timeout expires), acknowledged with a one-cycle pulse, and
// the bus is then held idle until the memory drops its completion level.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req0/1, we0/1       request level and direction (1 = write) per requester
//   addr0/1, wdata0/1   address and write data per requester
//   ack0/1              one-cycle completion pulse to the granted requester
//   err                 high with ack when the transaction timed out
//   rdata               read data, valid in the ack cycle
//   addressBus          memory address
//   memWData            memory write data (tristated onto dataBus at top)
//   memRWPin            memory direction, 1 = write, forced 0 when idle
//   memValid            memory transaction presented
//   memRData            memory read data
//   memOpDone           memory completion level (may stay high)
//   dbgState            current FSM state (IDLE=0, BUSY=1, RELEASE=2)
//
// Handshakes:
//   Requester side: reqN is a level held until ackN; addr/we/wdata are stable
//   while reqN is high. ackN pulses for exactly one cycle and the requester
//   drops reqN in the following cycle. Requests are only sampled in IDLE.
//   Memory side: memValid acts as "valid"; address/direction/data are frozen
//   while it is high. memOpDone acts as "ready/done": the first cycle it is
//   sampled high in BUSY completes the transfer. The memory may keep it high;
//   no new transfer starts until it has been sampled low again.

module mem_bus_arbiter #(
    parameter int TIMEOUT = 64,   // legal 2..255
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          err,
    output logic [31:0]   rdata,
    output logic [AW-1:0] addressBus,
    output logic [31:0]   memWData,
    output logic          memRWPin,
    output logic          memValid,
    input  logic [31:0]   memRData,
    input  logic          memOpDone,
    output logic [1:0]    dbgState
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arbState_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    arbState_t     state, stateNext;
    // Doubles as the id of the in-flight requester, since it is written
    // exactly when a grant is made.
    logic          lastServed, lastServedNext;
    logic [7:0]    timeoutCnt, timeoutCntNext;
    logic [AW-1:0] addressBusNext;
    logic [31:0]   memWDataNext;
    logic          memRWPinNext;
    logic          memValidNext;
    logic [31:0]   rdataNext;
    logic          ack0Next, ack1Next, errNext;
    logic          pick;

    assign dbgState = state;

    // Round-robin choice: on a tie serve the one not served last.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~lastServed;
        end else begin
            pick = req1;
        end
    end

    always_comb begin
        stateNext      = state;
        lastServedNext = lastServed;
        timeoutCntNext = timeoutCnt;
        addressBusNext = addressBus;
        memWDataNext   = memWData;
        memRWPinNext   = memRWPin;
        memValidNext   = memValid;
        rdataNext      = rdata;
        ack0Next       = 1'b0;
        ack1Next       = 1'b0;
        errNext        = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    lastServedNext = pick;
                    addressBusNext = pick ? addr1 : addr0;
                    memWDataNext   = pick ? wdata1 : wdata0;
                    memRWPinNext   = pick ? we1 : we0;
                    memValidNext   = 1'b1;
                    timeoutCntNext = 8'd0;
                    stateNext      = BUSY;
                end
            end
            BUSY: begin
                // Completion is checked before the timeout so that a
                // completion on the timeout edge still counts as success.
                if (memOpDone) begin
                    if (!memRWPin) begin
                        rdataNext = memRData;
                    end
                    ack0Next     = ~lastServed;
                    ack1Next     = lastServed;
                    memValidNext = 1'b0;
                    memRWPinNext = 1'b0;
                    stateNext    = RELEASE;
                end else if (timeoutCnt == TIMEOUT_LAST) begin
                    ack0Next     = ~lastServed;
                    ack1Next     = lastServed;
                    errNext      = 1'b1;
                    memValidNext = 1'b0;
                    memRWPinNext = 1'b0;
                    stateNext    = RELEASE;
                end else begin
                    timeoutCntNext = timeoutCnt + 8'd1;
                end
            end
            RELEASE: begin
                // Wait out a memory that keeps memOpDone high.
                if (!memOpDone) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lastServed <= 1'b1;     // requester 0 wins the first tie
            timeoutCnt <= 8'd0;
            addressBus <= '0;
            memWData   <= 32'd0;
            memRWPin   <= 1'b0;
            memValid   <= 1'b0;
            rdata      <= 32'd0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= stateNext;
            lastServed <= lastServedNext;
            timeoutCnt <= timeoutCntNext;
            addressBus <= addressBusNext;
            memWData   <= memWDataNext;
            memRWPin   <= memRWPinNext;
            memValid   <= memValidNext;
            rdata      <= rdataNext;
            ack0       <= ack0Next;
            ack1       <= ack1Next;
            err        <= errNext;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter (TIMEOUT = 8). The memory side is played by
// the serve task; expected acks {requester, err, rdata} are queued before each
// transaction and popped by a monitor whenever an ack is presented.

module tb_mem_bus_arbiter;

  localparam int AW = 32;

  logic          clk;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          ack0, ack1, err;
  logic [31:0]   rdata;
  logic [AW-1:0] addressBus;
  logic [31:0]   memWData;
  logic          memRWPin, memValid;
  logic [31:0]   memRData;
  logic          memOpDone;
  logic [1:0]    dbgState;

  int tests = 0;
  int fails = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_entry;

  mem_bus_arbiter #(.TIMEOUT(8), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
    .addressBus(addressBus), .memWData(memWData),
    .memRWPin(memRWPin), .memValid(memValid),
    .memRData(memRData), .memOpDone(memOpDone),
    .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic id, input logic e, input logic [31:0] rd);
    exp_q.push_back({id, e, rd});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (!memValid) check("rw_low_when_idle", 32'(memRWPin), 0);
      if (ack0 || ack1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: ack0=%0b ack1=%0b err=%0b, required no ack", ack0, ack1, err);
        end else begin
          mon_entry = exp_q.pop_front();
          check("ack_pair", {30'd0, ack1, ack0}, mon_entry[33] ? 32'd2 : 32'd1);
          check("ack_err", 32'(err), 32'(mon_entry[32]));
          check("ack_rdata", rdata, mon_entry[31:0]);
        end
      end else begin
        check("err_without_ack", 32'(err), 0);
      end
    end
  end

  task automatic wait_valid();
    int n;
    n = 0;
    while (!memValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("grant_valid", 32'(memValid), 1);
  endtask

  // memory driver: wait for the grant, check the bus, complete after delay
  task automatic serve(input logic [31:0] exp_addr, input logic exp_we, input logic [31:0] exp_wd,
                       input int delay_cycles, input logic [31:0] mem_data, input int hold_cycles);
    bit got_ack;
    wait_valid();
    check("bus_addr", addressBus, exp_addr);
    check("bus_rw", 32'(memRWPin), 32'(exp_we));
    check("bus_wdata", memWData, exp_wd);
    for (int i = 0; i < delay_cycles; i++) begin
      @(negedge clk);
      check("busy_hold", {memValid, memRWPin, addressBus[29:0]}, {1'b1, exp_we, exp_addr[29:0]});
    end
    memRData = mem_data;
    memOpDone = 1'b1;
    got_ack = 1'b0;
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        got_ack = 1'b1;
        if (ack0) req0 = 1'b0;
        if (ack1) req1 = 1'b0;
        check("valid_drop_at_ack", 32'(memValid), 0);
      end else if (got_ack) begin
        check("no_grant_in_release", 32'(memValid), 0);
      end
    end
    memOpDone = 1'b0;
    memRData = 32'h0;
    check("ack_seen", 32'(got_ack), 1);
  endtask

  // stimulus
  initial begin
    int n;
    int ack_at;
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = 0; wdata1 = 0;
    memRData = 0; memOpDone = 0;
    repeat (2) @(negedge clk);

    check("rst_memValid", 32'(memValid), 0);
    check("rst_memRWPin", 32'(memRWPin), 0);
    check("rst_addressBus", addressBus, 0);
    check("rst_memWData", memWData, 0);
    check("rst_rdata", rdata, 0);
    check("rst_acks_err", {29'd0, ack0, ack1, err}, 0);
    check("rst_state", 32'(dbgState), 0);
    reset = 1'b0;
    @(negedge clk);

    // both requesters held: grants 0,1,0,1
    req0 = 1; we0 = 0; addr0 = 32'h100; wdata0 = 0;
    req1 = 1; we1 = 1; addr1 = 32'h200; wdata1 = 32'hA5A5;
    push_exp(0, 0, 32'h11111111);
    serve(32'h100, 0, 0, 1, 32'h11111111, 1);
    @(negedge clk);
    req0 = 1; addr0 = 32'h104;
    push_exp(1, 0, 32'h11111111);
    serve(32'h200, 1, 32'hA5A5, 1, 32'hFFFFFFFF, 1);
    @(negedge clk);
    req1 = 1; addr1 = 32'h204; wdata1 = 32'h5A5A;
    push_exp(0, 0, 32'h22222222);
    serve(32'h104, 0, 0, 2, 32'h22222222, 1);
    push_exp(1, 0, 32'h22222222);
    serve(32'h204, 1, 32'h5A5A, 0, 32'hEEEEEEEE, 1);
    @(negedge clk);

    // read, memory completes 3 cycles after the grant is seen
    req0 = 1; we0 = 0; addr0 = 32'h10;
    push_exp(0, 0, 32'hDEADBEEF);
    serve(32'h10, 0, 0, 3, 32'hDEADBEEF, 1);
    @(negedge clk);

    // write leaves rdata unchanged, direction returns to read afterwards
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h55;
    push_exp(1, 0, 32'hDEADBEEF);
    serve(32'h20, 1, 32'h55, 2, 32'h13572468, 1);
    check("rw_after_write", 32'(memRWPin), 0);
    @(negedge clk);

    // memOpDone held 4 cycles while the other requester waits
    req0 = 1; we0 = 0; addr0 = 32'h30;
    req1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 32'h77;
    push_exp(0, 0, 32'hCAFEF00D);
    serve(32'h30, 0, 0, 1, 32'hCAFEF00D, 4);
    @(negedge clk);
    check("release_gap", 32'(memValid), 0);
    @(negedge clk);
    check("regrant_after_done_low", 32'(memValid), 1);
    push_exp(1, 0, 32'hCAFEF00D);
    serve(32'h40, 1, 32'h77, 1, 32'h0, 1);
    @(negedge clk);

    // timeout: memOpDone never asserted
    req1 = 1; we1 = 0; addr1 = 32'h50; wdata1 = 0;
    push_exp(1, 1, 32'hCAFEF00D);
    wait_valid();
    ack_at = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if ((ack0 || ack1) && ack_at == 0) begin
        ack_at = i;
        if (ack1) req1 = 1'b0;
        if (ack0) req0 = 1'b0;
        check("timeout_valid_drop", 32'(memValid), 0);
      end
    end
    check("timeout_latency", 32'(ack_at), 8);
    check("state_idle_after_timeout", 32'(dbgState), 0);

    // completion on the same edge as the timeout wins
    req0 = 1; we0 = 0; addr0 = 32'h60;
    push_exp(0, 0, 32'h0BADC0DE);
    serve(32'h60, 0, 0, 7, 32'h0BADC0DE, 1);
    @(negedge clk);

    // reset during BUSY aborts without ack
    req1 = 1; we1 = 1; addr1 = 32'h70; wdata1 = 32'h99;
    wait_valid();
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_memValid", 32'(memValid), 0);
    check("abort_memRWPin", 32'(memRWPin), 0);
    check("abort_addressBus", addressBus, 0);
    check("abort_memWData", memWData, 0);
    check("abort_rdata", rdata, 0);
    check("abort_acks_err", {29'd0, ack0, ack1, err}, 0);
    req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // after reset: tie goes to requester 0, then requester 1
    req0 = 1; we0 = 0; addr0 = 32'h80;
    req1 = 1; we1 = 1; addr1 = 32'h88; wdata1 = 32'h66;
    push_exp(0, 0, 32'h12345678);
    serve(32'h80, 0, 0, 1, 32'h12345678, 1);
    push_exp(1, 0, 32'h12345678);
    serve(32'h88, 1, 32'h66, 1, 32'h0, 1);
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
